// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer.
// State, source and push-select encodings plus the per-step control decode.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SRC_RES = 2'b00,
    SRC_NMI = 2'b01,
    SRC_BRK = 2'b10,
    SRC_IRQ = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    PUSH_NONE = 2'b00,
    PUSH_PCH  = 2'b01,
    PUSH_PCL  = 2'b10,
    PUSH_P    = 2'b11
  } push_e;

  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
  localparam logic [15:0] DEF_NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] DEF_RES_VEC    = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC    = 16'hFFFE;

  typedef struct packed {
    logic  seq_active;
    logic  rw;
    push_e push_sel;
    logic  b_flag;
    logic  sp_dec;
    logic  pcl_load;
    logic  pch_load;
    logic  set_i;
    logic  seq_done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    seq_active: 1'b0,
    rw:         1'b1,
    push_sel:   PUSH_NONE,
    b_flag:     1'b0,
    sp_dec:     1'b0,
    pcl_load:   1'b0,
    pch_load:   1'b0,
    set_i:      1'b0,
    seq_done:   1'b0
  };

  // Control strobes for one step; RES turns the three pushes into dummy reads.
  function automatic ctl_t step_ctl(input state_e st, input src_e s);
    ctl_t c;
    c = CTL_IDLE;
    case (st)
      ST_T1: c.seq_active = 1'b1;
      ST_T2: begin
        c.seq_active = 1'b1;
        c.push_sel   = PUSH_PCH;
        c.sp_dec     = 1'b1;
        c.rw         = (s == SRC_RES);
      end
      ST_T3: begin
        c.seq_active = 1'b1;
        c.push_sel   = PUSH_PCL;
        c.sp_dec     = 1'b1;
        c.rw         = (s == SRC_RES);
      end
      ST_T4: begin
        c.seq_active = 1'b1;
        c.push_sel   = PUSH_P;
        c.sp_dec     = 1'b1;
        c.rw         = (s == SRC_RES);
        c.b_flag     = (s == SRC_BRK);
      end
      ST_T5: begin
        c.seq_active = 1'b1;
        c.pcl_load   = 1'b1;
        c.set_i      = 1'b1;
      end
      ST_T6: begin
        c.seq_active = 1'b1;
        c.pch_load   = 1'b1;
        c.seq_done   = 1'b1;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] vec_sel(input src_e s, input logic [15:0] nmi_v,
                                          input logic [15:0] res_v, input logic [15:0] irq_v);
    case (s)
      SRC_RES: return res_v;
      SRC_NMI: return nmi_v;
      default: return irq_v;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI rising-edge latch: holds nmi_prev and nmi_pending; a new edge wins over a clear.
module interrupt_sequencer_nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_req,
  input  logic clr,
  output logic nmi_pending
);

  logic nmi_prev_q, nmi_prev_d;
  logic nmi_pending_q, nmi_pending_d;

  always_comb begin
    nmi_prev_d    = nmi_req;
    nmi_pending_d = nmi_pending_q;
    if (clr) nmi_pending_d = 1'b0;
    if (nmi_req && !nmi_prev_q) nmi_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_prev_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign nmi_pending = nmi_pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer: arbitrates RES/NMI/BRK/IRQ and drives six bus steps.
// Optional macro INTERRUPT_SEQ_NMI_HIJACK_EN lets a pending NMI take over a BRK/IRQ at T5.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
  parameter logic [15:0] NMI_VEC    = DEF_NMI_VEC,
  parameter logic [15:0] RES_VEC    = DEF_RES_VEC,
  parameter logic [15:0] IRQ_VEC    = DEF_IRQ_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        sync,
  input  logic        res_req,
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        brk_req,
  input  logic        flag_i,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  output logic        seq_active,
  output logic [15:0] addr,
  output logic        rw,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic        sp_dec,
  output logic        pcl_load,
  output logic        pch_load,
  output logic        set_i,
  output logic        seq_done,
  output logic [1:0]  src
);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        res_pending_q, res_pending_d;
  ctl_t        ctl_q, ctl_d;
  logic        nmi_pending;
  logic        nmi_clr;
  logic [15:0] vec;

  interrupt_sequencer_nmi_edge_detect u_nmi_edge_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .nmi_req     (nmi_req),
    .clr         (nmi_clr),
    .nmi_pending (nmi_pending)
  );

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    res_pending_d = res_pending_q | res_req;
    nmi_clr       = 1'b0;
    if (cpu_en) begin
      if (state_q != ST_IDLE && res_req) begin
        state_d = ST_T1;
        src_d   = SRC_RES;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (res_pending_q) begin
              state_d = ST_T1;
              src_d   = SRC_RES;
            end else if (sync) begin
              if (nmi_pending) begin
                state_d = ST_T1;
                src_d   = SRC_NMI;
              end else if (brk_req) begin
                state_d = ST_T1;
                src_d   = SRC_BRK;
              end else if (irq_req && !flag_i) begin
                state_d = ST_T1;
                src_d   = SRC_IRQ;
              end
            end
          end
          ST_T1: state_d = ST_T2;
          ST_T2: state_d = ST_T3;
          ST_T3: state_d = ST_T4;
          ST_T4: begin
            state_d = ST_T5;
`ifdef INTERRUPT_SEQ_NMI_HIJACK_EN
            if (nmi_pending && (src_q == SRC_BRK || src_q == SRC_IRQ)) src_d = SRC_NMI;
`endif
          end
          ST_T5: state_d = ST_T6;
          ST_T6: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
      // Within a cpu_en tick these only match on an actual step transition, never a hold.
      if (state_d == ST_T1 && src_d == SRC_RES) res_pending_d = 1'b0;
      if (state_q == ST_T4 && state_d == ST_T5 && src_d == SRC_NMI) nmi_clr = 1'b1;
    end
    ctl_d = step_ctl(state_d, src_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_RES;
      res_pending_q <= 1'b1;
      ctl_q         <= CTL_IDLE;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      res_pending_q <= res_pending_d;
      ctl_q         <= ctl_d;
    end
  end

  // Address follows the live PC/SP so the datapath's own decrements are honoured.
  always_comb begin
    vec = vec_sel(src_q, NMI_VEC, RES_VEC, IRQ_VEC);
    case (state_q)
      ST_T1:                addr = pc_in;
      ST_T2, ST_T3, ST_T4:  addr = {STACK_PAGE, sp_in};
      ST_T5:                addr = vec;
      ST_T6:                addr = vec + 16'd1;
      default:              addr = '0;
    endcase
  end

  assign seq_active = ctl_q.seq_active;
  assign rw         = ctl_q.rw;
  assign push_sel   = ctl_q.push_sel;
  assign b_flag     = ctl_q.b_flag;
  assign sp_dec     = ctl_q.sp_dec;
  assign pcl_load   = ctl_q.pcl_load;
  assign pch_load   = ctl_q.pch_load;
  assign set_i      = ctl_q.set_i;
  assign seq_done   = ctl_q.seq_done;
  assign src        = src_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Controls the 6502 datapath for the 6-step interrupt/reset entry sequence: dummy fetch, push PCH, push PCL, push P, fetch vector low, fetch vector high.
- Arbitrates RESET, NMI, BRK and IRQ by fixed priority, then drives the address mux, rw, stack-pointer decrement and PC-load strobes.
- Sits beside instruction_decode. It takes over the bus whenever seq_active=1.

Parameters:
- STACK_PAGE, 8'h01, high byte of every stack address.
- NMI_VEC, 16'hFFFA, NMI vector low-byte address. High byte is at +1.
- RES_VEC, 16'hFFFC, reset vector low-byte address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_en  in  1  one-clk step tick; all state advances only when cpu_en=1
- sync  in  1  instruction boundary from decode, qualified by cpu_en
- res_req  in  1  external reset request, level
- nmi_req  in  1  NMI line, active-high, edge-sensitive
- irq_req  in  1  IRQ line, active-high, level
- brk_req  in  1  decode has a BRK opcode, sampled at sync
- flag_i  in  1  interrupt-disable flag from the status register
- pc_in  in  16  current PC
- sp_in  in  8  current stack pointer
- seq_active  out  1  sequencer owns the bus
- addr  out  16  bus address
- rw  out  1  1=read, 0=write
- push_sel  out  2  data source: 00 none, 01 PCH, 10 PCL, 11 P
- b_flag  out  1  B bit value for the pushed P
- sp_dec  out  1  decrement SP at the end of this step
- pcl_load  out  1  load PCL from the data bus
- pch_load  out  1  load PCH from the data bus
- set_i  out  1  set the I flag
- seq_done  out  1  final step of a sequence
- src  out  2  active source: 00 RES, 01 NMI, 10 BRK, 11 IRQ

Behaviour:
- Registers:
  - State: IDLE, T1..T6.
  - src register.
  - res_pending, nmi_pending, nmi_prev.
- Outputs are a Moore decode of state and src, held for the whole step.
- rst_n=0 on a clk edge forces:
  - state=IDLE, src=00, res_pending=1, nmi_pending=0, nmi_prev=0.
  - This applies even mid-sequence. No partial strobes follow.
- Output values in IDLE (also the reset values): seq_active=0, addr=0, rw=1, push_sel=00, b_flag=0, sp_dec=0, pcl_load=0, pch_load=0, set_i=0, seq_done=0.
- res_pending:
  - Set while res_req=1.
  - Cleared on entering T1 with src=RES.
- nmi_pending:
  - Set on a 0->1 edge of nmi_req, detected on clk with nmi_prev.
  - Cleared on entering T5 with src=NMI.
  - A held-high nmi_req does not retrigger.
- Start, evaluated on cpu_en=1 while in IDLE:
  - res_pending=1 starts a sequence without waiting for sync.
  - Otherwise a sequence starts only when sync=1, with priority nmi_pending > brk_req > (irq_req & ~flag_i).
  - The chosen source latches into src and state goes to T1.
  - If nothing qualifies, state stays IDLE.
- Each step advances T1 -> T2 -> T3 -> T4 -> T5 -> T6 -> IDLE, one step per cpu_en.
- Per-step outputs:
  - T1: addr=pc_in, rw=1.
  - T2: addr={STACK_PAGE,sp_in}, push_sel=01, sp_dec=1.
  - T3: addr={STACK_PAGE,sp_in}, push_sel=10, sp_dec=1.
  - T4: addr={STACK_PAGE,sp_in}, push_sel=11, sp_dec=1, b_flag=(src==BRK).
  - T5: addr=vector base, rw=1, pcl_load=1, set_i=1.
  - T6: addr=vector base+1, rw=1, pch_load=1, seq_done=1.
- rw=0 in T2..T4, except src=RES: rw stays 1 (dummy stack reads) and sp_dec is still asserted.
- Vector base by src: RES -> RES_VEC, NMI -> NMI_VEC, BRK and IRQ -> IRQ_VEC.
- res_req=1 mid-sequence (any of T1..T6) overrides the running sequence:
  - At the next cpu_en, state goes to T1 with src=RES.
  - res_pending is cleared.
- An IRQ that drops before sync is lost. IRQ is level-sensitive and is not latched.
- Vector addresses use 16-bit arithmetic. Vector base+1 wraps modulo 2^16.

Optional Feature:
- Macro: INTERRUPT_SEQ_NMI_HIJACK_EN.
- When defined: if nmi_pending=1 when a BRK or IRQ sequence enters T5:
  - src becomes NMI and NMI_VEC is used.
  - nmi_pending is cleared.
  - The pushed B bit already written stays as written.
- When undefined: src is fixed for the whole sequence. A pending NMI is serviced at the next sync.

Decomposition:
- Shared include inc/interrupt_seq.vh holds:
  - state encodings (IDLE, T1..T6);
  - src codes (RES/NMI/BRK/IRQ);
  - push_sel codes;
  - default vector constants.
- One natural sub-module: nmi_edge_detect, which holds nmi_prev and nmi_pending with set/clear inputs.

Test Plan:
- Reset sequence: release rst_n, pc_in=0x1234, sp_in=0xFD, cpu_en every clk -> addr 0x1234, 0x01FD x3 with rw=1, 0xFFFC, 0xFFFD; pcl_load at step 5, pch_load at step 6; seq_done in the 6th step; sync is not required.
- IRQ masked vs unmasked:
  - irq_req=1, flag_i=1, sync pulses -> stays IDLE.
  - flag_i=0 -> src=11; rw=0 in T2..T4; b_flag=0; vector 0xFFFE.
- BRK: brk_req=1 at sync -> src=10, b_flag=1 in T4, vector 0xFFFE/0xFFFF.
- Priority: nmi edge, brk_req and irq_req all active at one sync -> src=01, vector 0xFFFA. An NMI held high afterwards does not retrigger.
- Reset abort: assert res_req during T3 of an IRQ sequence -> next step is T1 with src=00. Separately, rst_n=0 mid-T4 -> all outputs take their reset values on the next clk.
- Hijack, with the macro defined: NMI edge during T3 of a BRK sequence -> T5 addr=0xFFFA. With the macro undefined -> T5 addr=0xFFFE, and the NMI sequence starts at the next sync.
